// File: rtl/key_debounce_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : key_debounce_multi
// Purpose  : Multi-channel key debouncer. Each channel synchronises a raw
//            key pin and normalises its polarity. A change is accepted only
//            after DEB_CYCLES+1 consecutive matching samples. The channel then
//            produces a debounced level and one-cycle press, release and
//            long-press strobes.
// Ports    : i_clk          system clock
//            i_reset        asynchronous active-high reset
//            i_key          raw key pins, polarity set by ACTIVE_LOW
//            o_key_level    debounced state, 1 = pressed
//            o_key_press    one-cycle strobe on accepted press
//            o_key_release  one-cycle strobe on accepted release
//            o_key_long     one-cycle strobe LONG_CYCLES into a held press
// Revision : 1.0  initial release
// ============================================================================
module key_debounce_multi #(
    parameter int CH_NUM      = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [CH_NUM-1:0] i_key,
    output logic [CH_NUM-1:0] o_key_level,
    output logic [CH_NUM-1:0] o_key_press,
    output logic [CH_NUM-1:0] o_key_release,
    output logic [CH_NUM-1:0] o_key_long
);

    // Per-channel state encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] c_ST_PRESSED   = 2'd2;
    localparam logic [1:0] c_ST_REL_CHK   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    // LONG_CYCLES==0 disables the long strobe. The terminal value is then
    // never used, so park it at zero rather than underflowing.
    localparam logic [CNT_W-1:0] c_LONG_LAST =
        (LONG_CYCLES == 0) ? '0 : CNT_W'(LONG_CYCLES - 1);
    localparam logic c_LONG_EN = (LONG_CYCLES != 0);
    // Pin level of a released key. The synchroniser resets to it, so reset
    // release can never look like a press edge.
    localparam logic c_PIN_IDLE = (ACTIVE_LOW != 0);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             w_p;
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_dcnt;
        logic [CNT_W-1:0] w_dcnt_nxt;
        logic [CNT_W-1:0] r_hcnt;
        logic [CNT_W-1:0] w_hcnt_nxt;
        logic             r_long_done;
        logic             w_long_done_nxt;
        logic             r_level;
        logic             w_level_nxt;
        logic             r_press;
        logic             w_press_nxt;
        logic             r_release;
        logic             w_release_nxt;
        logic             r_long;
        logic             w_long_nxt;
        logic             w_deb_done;
        logic             w_enter_hold;
        logic             w_hold_nxt;

        // Normalised key: 1 = pressed, regardless of pin polarity
        assign w_p        = r_sync2 ^ c_PIN_IDLE;
        assign w_deb_done = (r_dcnt == c_DEB_LAST);

        // ---------------------------------------------------------------
        // State register: synchroniser, FSM, counters and output strobes
        // ---------------------------------------------------------------
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_sync1     <= c_PIN_IDLE;
                r_sync2     <= c_PIN_IDLE;
                r_state     <= c_ST_IDLE;
                r_dcnt      <= '0;
                r_hcnt      <= '0;
                r_long_done <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
            end else begin
                r_sync1     <= i_key[g];
                r_sync2     <= r_sync1;
                r_state     <= w_state_nxt;
                r_dcnt      <= w_dcnt_nxt;
                r_hcnt      <= w_hcnt_nxt;
                r_long_done <= w_long_done_nxt;
                r_level     <= w_level_nxt;
                r_press     <= w_press_nxt;
                r_release   <= w_release_nxt;
                r_long      <= w_long_nxt;
            end
        end

        // ---------------------------------------------------------------
        // Next-state logic and debounce counter
        // ---------------------------------------------------------------
        always_comb begin
            w_state_nxt = r_state;
            w_dcnt_nxt  = r_dcnt;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_p) begin
                        w_state_nxt = c_ST_PRESS_CHK;
                        w_dcnt_nxt  = '0;
                    end
                end
                c_ST_PRESS_CHK: begin
                    if (!w_p) begin
                        // Bounce: drop back without any strobe
                        w_state_nxt = c_ST_IDLE;
                    end else if (w_deb_done) begin
                        w_state_nxt = c_ST_PRESSED;
                    end else begin
                        w_dcnt_nxt = r_dcnt + c_CNT_ONE;
                    end
                end
                c_ST_PRESSED: begin
                    if (!w_p) begin
                        w_state_nxt = c_ST_REL_CHK;
                        w_dcnt_nxt  = '0;
                    end
                end
                c_ST_REL_CHK: begin
                    if (w_p) begin
                        // Release bounce: resume the held press
                        w_state_nxt = c_ST_PRESSED;
                    end else if (w_deb_done) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_dcnt_nxt = r_dcnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_dcnt_nxt  = '0;
                end
            endcase
        end

        // ---------------------------------------------------------------
        // Output logic: level, strobes and the hold/long-press tracking
        // ---------------------------------------------------------------
        always_comb begin
            w_enter_hold  = (r_state == c_ST_PRESS_CHK) &&
                            (w_state_nxt == c_ST_PRESSED);
            w_hold_nxt    = (w_state_nxt == c_ST_PRESSED) ||
                            (w_state_nxt == c_ST_REL_CHK);
            w_press_nxt   = w_enter_hold;
            w_release_nxt = (r_state == c_ST_REL_CHK) &&
                            (w_state_nxt == c_ST_IDLE);
            // Level stays 1 through release checking, so it only tracks
            // accepted transitions.
            w_level_nxt   = w_hold_nxt;

            // Hold counter restarts on every accepted press and saturates
            // at its terminal value, so it can never wrap.
            w_hcnt_nxt = r_hcnt;
            if (w_enter_hold) begin
                w_hcnt_nxt = '0;
            end else if (w_hold_nxt && c_LONG_EN && (r_hcnt != c_LONG_LAST)) begin
                w_hcnt_nxt = r_hcnt + c_CNT_ONE;
            end

            // The strobe is registered together with the hold count that
            // reaches the terminal value, so both are visible in the same cycle.
            // long_done is ignored on entry because it belongs to the
            // previous press.
            w_long_nxt = c_LONG_EN && w_hold_nxt &&
                         (w_hcnt_nxt == c_LONG_LAST) &&
                         (w_enter_hold || !r_long_done);

            if (w_enter_hold) begin
                w_long_done_nxt = w_long_nxt;
            end else begin
                w_long_done_nxt = r_long_done | w_long_nxt;
            end
        end

        assign o_key_level[g]   = r_level;
        assign o_key_press[g]   = r_press;
        assign o_key_release[g] = r_release;
        assign o_key_long[g]    = r_long;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_debounce_multi
// Purpose  : Self-checking bench for key_debounce_multi. A reference model
//            counts consecutive disagreeing samples and the cycles a key has
//            been held. It pushes the expected output vector for every clock
//            into a scoreboard. A monitor pops and compares at each falling
//            edge. Directed latency and strobe-count checks cover the
//            scenarios called out for this block. Random pin activity follows.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int CH   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] key;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] lng;

    key_debounce_multi #(
        .CH_NUM      (CH),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG),
        .CNT_W       (CW),
        .ACTIVE_LOW  (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_key         (key),
        .o_key_level   (level),
        .o_key_press   (press),
        .o_key_release (rel),
        .o_key_long    (lng)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   press_cnt[CH];
    int   rel_cnt[CH];
    int   long_cnt[CH];
    int   press_cyc[CH];
    int   rel_cyc[CH];
    int   long_cyc[CH];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive the pins, hold them for n cycles and return just after a
    // falling edge.
    task automatic apply(input logic [CH-1:0] v, input int n);
        key = v;
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model. A key's debounced state flips once DEB+1 consecutive
    // synchronised samples disagree with it. The long strobe fires when a
    // press has been held LONG-1 cycles beyond the accepting cycle.
    initial begin : model
        logic [CH-1:0] h1;
        logic [CH-1:0] h2;
        logic [CH-1:0] lv;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] lg;
        logic          p;
        int            run[CH];
        int            age[CH];
        exp_t          e;
        h1 = '1;
        h2 = '1;
        lv = '0;
        for (int c = 0; c < CH; c++) begin
            run[c] = 0;
            age[c] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            pr = '0;
            rl = '0;
            lg = '0;
            if (rst) begin
                h1 = '1;
                h2 = '1;
                lv = '0;
                for (int c = 0; c < CH; c++) begin
                    run[c] = 0;
                    age[c] = 0;
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    p = ~h2[c];
                    if (p != lv[c]) run[c]++;
                    else run[c] = 0;
                    if (run[c] == DEB + 1) begin
                        lv[c]  = p;
                        run[c] = 0;
                        if (p) begin
                            pr[c]  = 1'b1;
                            age[c] = 0;
                        end else begin
                            rl[c] = 1'b1;
                        end
                    end else if (lv[c]) begin
                        age[c]++;
                        if (age[c] == LONG - 1) lg[c] = 1'b1;
                    end
                end
                h2 = h1;
                h1 = key;
            end
            e.c = cyc;
            e.v = {lv, pr, rl, lg};
            sb.push_back(e);
        end
    end

    // Monitor: record strobe timing and compare every cycle's outputs.
    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        for (int c = 0; c < CH; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
            press_cyc[c] = 0; rel_cyc[c] = 0; long_cyc[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (press[c] === 1'b1) begin press_cnt[c]++; press_cyc[c] = cyc; end
                if (rel[c]   === 1'b1) begin rel_cnt[c]++;   rel_cyc[c]   = cyc; end
                if (lng[c]   === 1'b1) begin long_cnt[c]++;  long_cyc[c]  = cyc; end
            end
            act = {level, press, rel, lng};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: cycle %0d has no expected entry", cyc);
            end else begin
                e = sb.pop_front();
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got lvl/prs/rel/lng=%b expected %b",
                             e.c, act, e.v);
                end
            end
        end
    end

    initial begin : stim
        int            t0;
        int            pc;
        int            rc;
        int            lc;
        int            n;
        logic [CH-1:0] v;
        rst = 1'b1;
        key = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", int'({level, press, rel, lng}), 0);
        rst = 1'b0;
        apply(2'b11, 50);

        // Clean press then release on ch0
        t0 = cyc; pc = press_cnt[0];
        apply(2'b10, 12);
        chk("press_latency", press_cyc[0] - t0, DEB + 3);
        chk("press_count", press_cnt[0] - pc, 1);
        chk("ch1_no_press", press_cnt[1], 0);
        chk("press_level", int'(level[0]), 1);
        t0 = cyc;
        apply(2'b11, 12);
        chk("release_latency", rel_cyc[0] - t0, DEB + 3);
        chk("release_level", int'(level[0]), 0);

        // Press bounce rejection
        pc = press_cnt[0];
        repeat (5) begin
            apply(2'b10, 3);
            apply(2'b11, 3);
        end
        chk("bounce_no_press", press_cnt[0] - pc, 0);
        chk("bounce_level", int'(level[0]), 0);
        apply(2'b11, 10);

        // Release glitch rejection
        apply(2'b10, 12);
        rc = rel_cnt[0];
        apply(2'b11, 2);
        apply(2'b10, 6);
        chk("glitch_no_release", rel_cnt[0] - rc, 0);
        chk("glitch_level", int'(level[0]), 1);
        apply(2'b11, 12);

        // Long press
        lc = long_cnt[0];
        apply(2'b10, 40);
        chk("long_after_press", long_cyc[0] - press_cyc[0], LONG - 1);
        chk("long_single", long_cnt[0] - lc, 1);
        t0 = cyc;
        apply(2'b11, 12);
        chk("long_release_latency", rel_cyc[0] - t0, DEB + 3);

        // Simultaneous and staggered channels
        apply(2'b00, 12);
        chk("simul_press", press_cyc[1] - press_cyc[0], 0);
        apply(2'b11, 12);
        apply(2'b10, 1);
        apply(2'b00, 12);
        chk("stagger_press", press_cyc[1] - press_cyc[0], 1);
        apply(2'b11, 12);

        // Reset while pressed, key still held on release of reset
        apply(2'b10, 12);
        rc = rel_cnt[0];
        rst = 1'b1;
        #1;
        chk("reset_mid_clear", int'({level, press, rel, lng}), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc; pc = press_cnt[0];
        apply(2'b10, 12);
        chk("reset_repress_latency", press_cyc[0] - t0, DEB + 3);
        chk("reset_repress_count", press_cnt[0] - pc, 1);
        chk("reset_no_release", rel_cnt[0] - rc, 0);
        apply(2'b11, 12);

        // Random pin activity with occasional resets
        for (int i = 0; i < 250; i++) begin
            v = 2'($urandom);
            if ($urandom_range(0, 3) == 0) n = int'($urandom_range(20, 35));
            else n = int'($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                #1;
                rst = 1'b0;
            end
            apply(v, n);
        end
        apply(2'b11, 30);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
